// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch predictor: 2-bit direction counter encoding and helpers.
package branch_predictor_pkg;

    // Saturating direction counter; bit 1 set means predict taken.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_t;

    localparam bp_ctr_t BP_CTR_INIT = WNT;

    // Sequential next PC for a 32-bit instruction; wraps at 2**32.
    function automatic logic [31:0] bp_next_seq(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup, EX-side resolve and perf-counter signals of the branch predictor.
interface branch_predictor_if #(
    parameter int unsigned CNT_WIDTH = 32
);
    // IF lookup
    logic                 if_valid;
    logic [31:0]          if_pc;
    logic                 pred_taken;
    logic [31:0]          pred_target;
    // EX resolve
    logic                 ex_valid;
    logic                 ex_is_branch;
    logic                 ex_stall;
    logic [31:0]          ex_pc;
    logic [31:0]          ex_target;
    logic                 ex_br_en;
    logic                 ex_pred_taken;
    logic [31:0]          ex_pred_target;
    logic                 mispredict;
    logic [31:0]          redirect_pc;
    // Performance counters
    logic [CNT_WIDTH-1:0] branch_count;
    logic [CNT_WIDTH-1:0] mispredict_count;

    // Pipeline side: drives fetch/EX information, consumes predictions and redirects.
    modport master (
        output if_valid, if_pc,
        output ex_valid, ex_is_branch, ex_stall, ex_pc, ex_target, ex_br_en,
        output ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, mispredict, redirect_pc,
        input  branch_count, mispredict_count
    );

    // Predictor side.
    modport slave (
        input  if_valid, if_pc,
        input  ex_valid, ex_is_branch, ex_stall, ex_pc, ex_target, ex_br_en,
        input  ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, mispredict, redirect_pc,
        output branch_count, mispredict_count
    );

endinterface

// File: rtl/bp_sat_counter.sv
// Next state of one 2-bit saturating direction counter given the resolved outcome.
module bp_sat_counter
    import branch_predictor_pkg::*;
(
    input  bp_ctr_t ctr_i,
    input  logic    taken_i,
    output bp_ctr_t ctr_o
);

    // Step towards ST on taken, towards SNT on not-taken, holding at the ends.
    always_comb begin
        ctr_o = ctr_i;
        case (ctr_i)
            SNT:     ctr_o = taken_i ? WNT : SNT;
            WNT:     ctr_o = taken_i ? WT  : SNT;
            WT:      ctr_o = taken_i ? ST  : WNT;
            ST:      ctr_o = taken_i ? ST  : WT;
            default: ctr_o = BP_CTR_INIT;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational IF prediction, EX-side
// mispredict detection, table training and performance counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned IDX_BITS  = 6,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    branch_predictor_if.slave bp
);

    localparam int unsigned NumEntries = 2 ** IDX_BITS;
    localparam int unsigned TagWidth   = 32 - IDX_BITS - 2;

    logic                valid_q  [NumEntries];
    logic                valid_d  [NumEntries];
    logic [TagWidth-1:0] tag_q    [NumEntries];
    logic [TagWidth-1:0] tag_d    [NumEntries];
    logic [31:0]         target_q [NumEntries];
    logic [31:0]         target_d [NumEntries];
    bp_ctr_t             ctr_q    [NumEntries];
    bp_ctr_t             ctr_d    [NumEntries];

    logic [CNT_WIDTH-1:0] branch_count_q, branch_count_d;
    logic [CNT_WIDTH-1:0] mispredict_count_q, mispredict_count_d;

    logic [IDX_BITS-1:0] if_idx, ex_idx;
    logic [TagWidth-1:0] if_tag, ex_tag;
    logic                if_hit, ex_hit;
    logic                upd;
    logic                mispredict;
    logic [31:0]         actual_next;
    bp_ctr_t             ex_ctr_next;

    assign if_idx = bp.if_pc[IDX_BITS+1:2];
    assign if_tag = bp.if_pc[31:IDX_BITS+2];
    assign ex_idx = bp.ex_pc[IDX_BITS+1:2];
    assign ex_tag = bp.ex_pc[31:IDX_BITS+2];

    // Byte-offset bits and the carried direction bit do not affect the result.
    logic unused_bits;
    assign unused_bits = ^{bp.if_pc[1:0], bp.ex_pc[1:0], bp.ex_pred_taken};

    // IF lookup reads the registered table, so a same-cycle write is not visible.
    always_comb begin
        if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        bp.pred_taken  = ~rst & bp.if_valid & if_hit & ctr_q[if_idx][1];
        bp.pred_target = bp.pred_taken ? target_q[if_idx] : bp_next_seq(bp.if_pc);
    end

    // Resolve: compare the real next PC with the one fetch actually followed.
    always_comb begin
        upd         = ~rst & bp.ex_valid & bp.ex_is_branch & ~bp.ex_stall;
        actual_next = bp.ex_br_en ? bp.ex_target : bp_next_seq(bp.ex_pc);
        mispredict  = upd & (actual_next != bp.ex_pred_target);
        ex_hit      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    end

    assign bp.mispredict  = mispredict;
    assign bp.redirect_pc = mispredict ? actual_next : 32'd0;

    bp_sat_counter u_sat_counter (
        .ctr_i   (ctr_q[ex_idx]),
        .taken_i (bp.ex_br_en),
        .ctr_o   (ex_ctr_next)
    );

    // Table training: update on hit, allocate only for taken misses.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (upd) begin
            if (ex_hit) begin
                ctr_d[ex_idx] = ex_ctr_next;
                if (bp.ex_br_en) begin
                    target_d[ex_idx] = bp.ex_target;
                end
            end else if (bp.ex_br_en) begin
                valid_d[ex_idx]  = 1'b1;
                tag_d[ex_idx]    = ex_tag;
                target_d[ex_idx] = bp.ex_target;
                ctr_d[ex_idx]    = WT;
            end
        end
    end

    // Performance counters advance once per resolved branch and wrap naturally.
    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (upd) begin
            branch_count_d = branch_count_q + 1'b1;
        end
        if (mispredict) begin
            mispredict_count_d = mispredict_count_q + 1'b1;
        end
    end

    assign bp.branch_count     = branch_count_q;
    assign bp.mispredict_count = mispredict_count_q;

    // Table and counter state; reset clears every entry and discards in-flight training.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NumEntries; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= BP_CTR_INIT;
            end
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            valid_q            <= valid_d;
            tag_q              <= tag_d;
            target_q           <= target_d;
            ctr_q              <= ctr_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with hand-computed expected values.
module tb_branch_predictor;

    logic clk = 1'b0;
    logic rst;

    branch_predictor_if #(.CNT_WIDTH(32)) bp_if ();

    branch_predictor #(
        .IDX_BITS  (6),
        .CNT_WIDTH (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bp_if.ex_valid       = 1'b0;
        bp_if.ex_is_branch   = 1'b0;
        bp_if.ex_stall       = 1'b0;
        bp_if.ex_pc          = 32'd0;
        bp_if.ex_target      = 32'd0;
        bp_if.ex_br_en       = 1'b0;
        bp_if.ex_pred_taken  = 1'b0;
        bp_if.ex_pred_target = 32'd0;
    endtask

    task automatic drive_br(input logic [31:0] pc, input logic [31:0] tgt, input logic taken,
                            input logic [31:0] ptgt, input logic stall);
        bp_if.ex_valid       = 1'b1;
        bp_if.ex_is_branch   = 1'b1;
        bp_if.ex_stall       = stall;
        bp_if.ex_pc          = pc;
        bp_if.ex_target      = tgt;
        bp_if.ex_br_en       = taken;
        bp_if.ex_pred_taken  = (ptgt != pc + 32'd4);
        bp_if.ex_pred_target = ptgt;
    endtask

    task automatic lookup(input logic [31:0] pc);
        bp_if.if_valid = 1'b1;
        bp_if.if_pc    = pc;
    endtask

    task automatic check_pred(input string tag, input logic taken, input logic [31:0] tgt);
        check_eq({tag, ".taken"}, {31'd0, bp_if.pred_taken}, {31'd0, taken});
        check_eq({tag, ".target"}, bp_if.pred_target, tgt);
    endtask

    task automatic check_redir(input string tag, input logic mp, input logic [31:0] pc);
        check_eq({tag, ".mispredict"}, {31'd0, bp_if.mispredict}, {31'd0, mp});
        check_eq({tag, ".redirect"}, bp_if.redirect_pc, pc);
    endtask

    task automatic check_counts(input string tag, input logic [31:0] br, input logic [31:0] mp);
        check_eq({tag, ".branch_count"}, bp_if.branch_count, br);
        check_eq({tag, ".mispredict_count"}, bp_if.mispredict_count, mp);
    endtask

    initial begin
        // Reset with a would-be mispredicting branch present in EX.
        rst = 1'b1;
        lookup(32'h60);
        drive_br(32'h100, 32'h80, 1'b1, 32'h104, 1'b0);
        #3;
        check_pred("reset", 1'b0, 32'h64);
        check_redir("reset", 1'b0, 32'h0);
        check_counts("reset", 32'd0, 32'd0);
        #4;
        rst = 1'b0;
        set_idle();

        // Cold taken branch; same-cycle lookup still misses.
        tick();
        drive_br(32'h100, 32'h80, 1'b1, 32'h104, 1'b0);
        lookup(32'h100);
        #1;
        check_redir("cold", 1'b1, 32'h80);
        check_pred("cold_same", 1'b0, 32'h104);
        tick();
        set_idle();
        #1;
        check_pred("cold_next", 1'b1, 32'h80);
        check_counts("cold", 32'd1, 32'd1);

        // Saturate: WT -> ST, ST, ST with correct predictions.
        for (int i = 0; i < 3; i++) begin
            tick();
            drive_br(32'h100, 32'h80, 1'b1, 32'h80, 1'b0);
            #1;
            check_redir("sat_taken", 1'b0, 32'h0);
        end
        tick();
        drive_br(32'h100, 32'h80, 1'b0, 32'h80, 1'b0);
        #1;
        check_redir("nt1", 1'b1, 32'h104);
        tick();
        set_idle();
        #1;
        check_pred("after_nt1", 1'b1, 32'h80);
        check_counts("after_nt1", 32'd5, 32'd2);
        tick();
        drive_br(32'h100, 32'h80, 1'b0, 32'h80, 1'b0);
        #1;
        check_redir("nt2", 1'b1, 32'h104);
        tick();
        set_idle();
        #1;
        check_pred("after_nt2", 1'b0, 32'h104);
        check_counts("after_nt2", 32'd6, 32'd3);

        // Aliasing: 0x200 shares index 0 and replaces the entry.
        tick();
        drive_br(32'h200, 32'h300, 1'b1, 32'h204, 1'b0);
        #1;
        check_redir("alias", 1'b1, 32'h300);
        tick();
        set_idle();
        lookup(32'h100);
        #1;
        check_pred("alias_old", 1'b0, 32'h104);
        tick();
        lookup(32'h200);
        #1;
        check_pred("alias_new", 1'b1, 32'h300);
        check_counts("alias", 32'd7, 32'd4);

        // Cold not-taken branch must not allocate.
        tick();
        drive_br(32'h40, 32'h10, 1'b0, 32'h44, 1'b0);
        #1;
        check_redir("cold_nt", 1'b0, 32'h0);
        tick();
        set_idle();
        lookup(32'h40);
        #1;
        check_pred("cold_nt_next", 1'b0, 32'h44);
        check_counts("cold_nt", 32'd8, 32'd4);

        // Non-branch in EX neither redirects, counts nor trains.
        tick();
        drive_br(32'h100, 32'h80, 1'b1, 32'h0, 1'b0);
        bp_if.ex_is_branch = 1'b0;
        #1;
        check_redir("nonbr", 1'b0, 32'h0);
        tick();
        set_idle();
        lookup(32'h100);
        #1;
        check_pred("nonbr_next", 1'b0, 32'h104);
        check_counts("nonbr", 32'd8, 32'd4);
        bp_if.if_valid = 1'b0;
        bp_if.if_pc    = 32'h200;
        #1;
        check_pred("if_invalid", 1'b0, 32'h204);

        // Stall for three cycles, then release: resolves exactly once.
        for (int i = 0; i < 3; i++) begin
            tick();
            drive_br(32'h400, 32'h500, 1'b1, 32'h404, 1'b1);
            #1;
            check_redir("stall", 1'b0, 32'h0);
        end
        tick();
        check_counts("stall_held", 32'd8, 32'd4);
        drive_br(32'h400, 32'h500, 1'b1, 32'h404, 1'b0);
        #1;
        check_redir("stall_release", 1'b1, 32'h500);
        tick();
        set_idle();
        lookup(32'h400);
        #1;
        check_pred("stall_next", 1'b1, 32'h500);
        check_counts("stall_done", 32'd9, 32'd5);

        // Same-cycle read/write on index 5: old entry, then new entry.
        tick();
        drive_br(32'h14, 32'h700, 1'b1, 32'h18, 1'b0);
        lookup(32'h14);
        #1;
        check_pred("rw_alloc_same", 1'b0, 32'h18);
        check_redir("rw_alloc", 1'b1, 32'h700);
        tick();
        set_idle();
        #1;
        check_pred("rw_alloc_next", 1'b1, 32'h700);
        check_counts("rw_alloc", 32'd10, 32'd6);
        tick();
        drive_br(32'h14, 32'h700, 1'b0, 32'h700, 1'b0);
        #1;
        check_pred("rw_dec_same", 1'b1, 32'h700);
        check_redir("rw_dec", 1'b1, 32'h18);
        tick();
        set_idle();
        #1;
        check_pred("rw_dec_next", 1'b0, 32'h18);
        check_counts("rw_dec", 32'd11, 32'd7);

        // Asynchronous reset pulse between edges clears table and counters.
        tick();
        lookup(32'h400);
        #1;
        check_pred("pre_rst", 1'b1, 32'h500);
        rst = 1'b1;
        #1;
        check_pred("in_rst", 1'b0, 32'h404);
        check_counts("in_rst", 32'd0, 32'd0);
        #1;
        rst = 1'b0;
        tick();
        #1;
        check_pred("post_rst", 1'b0, 32'h404);
        lookup(32'h80);
        #1;
        check_pred("post_rst_80", 1'b0, 32'h84);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
